// File: rtl/boot_pkg.sv
// Shared types and constants for the program-image boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        FILL_TEXT,
        FILL_DATA,
        DONE,
        ERR
    } boot_state_t;

    localparam logic [1:0]  KIND_TEXT   = 2'b00;
    localparam logic [1:0]  KIND_DATA   = 2'b01;
    localparam logic [1:0]  KIND_END    = 2'b11;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/boot_addr_gen.sv
// Section address generator: base + 4*index, with a limit that can be raised
// mid-section so the fill phase continues from where the payload stopped.
module boot_addr_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        relimit,
    input  logic        step,
    input  logic [31:0] base_in,
    input  logic [15:0] limit_in,
    output logic [31:0] addr,
    output logic        last,
    output logic        over
);

    logic [31:0] base;
    logic [15:0] idx;
    logic [15:0] limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            limit <= '0;
        end else if (load) begin
            idx   <= '0;
            limit <= limit_in;
        end else begin
            if (relimit) limit <= limit_in;
            if (step)    idx   <= idx + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) base <= base_in;
    end

    assign addr = base + {14'b0, idx, 2'b00};
    assign last = ({1'b0, idx} + 17'd1) == {1'b0, limit};
    assign over = idx >= limit;

endmodule

// File: rtl/mem_boot_loader.sv
// Streams a TEXT/DATA/END program image into memory with NOP/zero padding,
// holding the CPU in reset until the END header is accepted.
module mem_boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = 32'h0001_0000,
    parameter int          PAD_WORDS  = 32,
    parameter int          TEXT_WORDS = 100,
    parameter int          DATA_WORDS = 100,
    parameter logic [31:0] DATA_GAP   = 32'd8,
    parameter logic [31:0] NOP_WORD   = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic [31:0] eof_addr,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] PAD_L  = 16'(PAD_WORDS);
    localparam logic [15:0] DATA_L = 16'(DATA_WORDS);

    boot_state_t state, state_d;
    logic        text_seen, data_seen, sect_text, sect_text_d;
    logic        set_ts, set_ds, latch_eof;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        ag_load, ag_relimit, ag_step, ag_last, ag_over;
    logic [31:0] ag_base, ag_addr;
    logic [15:0] ag_limit;

    logic [1:0]  hdr_kind;
    logic [15:0] hdr_len;
    logic        len_over_text, len_over_data;

    assign hdr_kind      = in_data[31:30];
    assign hdr_len       = in_data[15:0];
    assign len_over_text = {16'b0, hdr_len} > 32'(TEXT_WORDS);
    assign len_over_data = {16'b0, hdr_len} > 32'(DATA_WORDS);

    boot_addr_gen u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (ag_load),
        .relimit  (ag_relimit),
        .step     (ag_step),
        .base_in  (ag_base),
        .limit_in (ag_limit),
        .addr     (ag_addr),
        .last     (ag_last),
        .over     (ag_over)
    );

    always_comb begin
        state_d     = state;
        sect_text_d = sect_text;
        wr_en       = 1'b0;
        wr_addr     = ag_addr;
        wr_data     = in_data;
        ag_load     = 1'b0;
        ag_relimit  = 1'b0;
        ag_step     = 1'b0;
        ag_base     = TEXT_BASE;
        ag_limit    = hdr_len;
        set_ts      = 1'b0;
        set_ds      = 1'b0;
        latch_eof   = 1'b0;
        case (state)
            IDLE: state_d = HDR;
            HDR: begin
                if (in_valid) begin
                    case (hdr_kind)
                        KIND_TEXT: begin
                            if (text_seen || len_over_text) begin
                                state_d = ERR;
                            end else begin
                                latch_eof   = 1'b1;
                                ag_load     = 1'b1;
                                sect_text_d = 1'b1;
                                if (hdr_len == 16'd0) begin
                                    ag_limit = PAD_L;
                                    state_d  = FILL_TEXT;
                                end else begin
                                    state_d  = LOAD;
                                end
                            end
                        end
                        KIND_DATA: begin
                            if (!text_seen || data_seen || len_over_data) begin
                                state_d = ERR;
                            end else begin
                                ag_load     = 1'b1;
                                ag_base     = eof_addr + DATA_GAP;
                                sect_text_d = 1'b0;
                                if (hdr_len == 16'd0) begin
                                    ag_limit = DATA_L;
                                    state_d  = FILL_DATA;
                                end else begin
                                    state_d  = LOAD;
                                end
                            end
                        end
                        KIND_END: state_d = text_seen ? DONE : ERR;
                        default:  state_d = ERR;
                    endcase
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    ag_step = 1'b1;
                    if (ag_last) begin
                        // Keep the index running; only the limit moves to the fill span.
                        ag_relimit = 1'b1;
                        ag_limit   = sect_text ? PAD_L : DATA_L;
                        state_d    = sect_text ? FILL_TEXT : FILL_DATA;
                    end
                end
            end
            FILL_TEXT, FILL_DATA: begin
                if (ag_over) begin
                    set_ts  = (state == FILL_TEXT);
                    set_ds  = (state == FILL_DATA);
                    state_d = HDR;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = (state == FILL_TEXT) ? NOP_WORD : 32'd0;
                    ag_step = 1'b1;
                    if (ag_last) begin
                        set_ts  = (state == FILL_TEXT);
                        set_ds  = (state == FILL_DATA);
                        state_d = HDR;
                    end
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sect_text <= 1'b0;
            text_seen <= 1'b0;
            data_seen <= 1'b0;
            eof_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            sect_text <= sect_text_d;
            mem_wen   <= wr_en;
            if (set_ts)    text_seen <= 1'b1;
            if (set_ds)    data_seen <= 1'b1;
            if (latch_eof) eof_addr  <= TEXT_BASE + {14'b0, hdr_len, 2'b00};
            if (wr_en) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

    assign in_ready = (state == HDR) || (state == LOAD);
    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign cpu_rst  = (state != DONE);

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: table of image streams plus random streams,
// checked against a section-level model of the expected memory image.
module tb_mem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready, mem_wen, cpu_rst, done, error;
    logic [31:0] mem_addr, mem_wdata, eof_addr;

    always #5 clk = ~clk;

    mem_boot_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .eof_addr  (eof_addr),
        .done      (done),
        .error     (error)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [3:0][31:0] h;
        int               nh;
        logic             e_done;
        logic             e_err;
        logic [31:0]      e_eof;
        int               e_nwr;
    } vec_t;

    int  total = 0;
    int  bad   = 0;
    wr_t got_q[$];
    bit  collect = 0;

    always @(negedge clk) begin
        if (collect && mem_wen) got_q.push_back('{mem_addr, mem_wdata});
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(int nh, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                logic [31:0] d, logic ed, logic ee, logic [31:0] eof, int nwr);
        vec_t v;
        v.h[0] = a; v.h[1] = b; v.h[2] = c; v.h[3] = d;
        v.nh = nh; v.e_done = ed; v.e_err = ee; v.e_eof = eof; v.e_nwr = nwr;
        return v;
    endfunction

    // Expected memory image and outcome, derived section by section from the stream.
    task automatic model(input logic [31:0] s[$], output wr_t w[$], output bit pay[$],
                         output int used, output bit md, output bit me, output logic [31:0] meof);
        int          p = 0;
        int          len;
        bit          ts = 0, ds = 0;
        logic [31:0] hdr, db;
        w.delete(); pay.delete();
        md = 0; me = 0; meof = 0;
        for (int i = 0; i < s.size(); i++) pay.push_back(1'b0);
        while (p < s.size() && !md && !me) begin
            hdr = s[p]; p++;
            len = int'(hdr[15:0]);
            case (hdr[31:30])
                2'b00: begin
                    if (ts || len > 100) me = 1;
                    else begin
                        meof = 32'h10000 + 32'(4 * len);
                        for (int i = 0; i < len; i++) begin
                            w.push_back('{32'h10000 + 32'(4 * i), s[p]}); pay[p] = 1'b1; p++;
                        end
                        for (int i = len; i < 32; i++) w.push_back('{32'h10000 + 32'(4 * i), 32'h13});
                        ts = 1;
                    end
                end
                2'b01: begin
                    if (!ts || ds || len > 100) me = 1;
                    else begin
                        db = meof + 32'd8;
                        for (int i = 0; i < len; i++) begin
                            w.push_back('{db + 32'(4 * i), s[p]}); pay[p] = 1'b1; p++;
                        end
                        for (int i = len; i < 100; i++) w.push_back('{db + 32'(4 * i), 32'h0});
                        ds = 1;
                    end
                end
                2'b11: begin
                    if (!ts) me = 1; else md = 1;
                end
                default: me = 1;
            endcase
        end
        used = p;
    endtask

    task automatic build(input logic [31:0] hs[$], output logic [31:0] s[$]);
        s.delete();
        foreach (hs[k]) begin
            s.push_back(hs[k]);
            if (hs[k][31] == 1'b0)
                for (int i = 0; i < int'(hs[k][15:0]); i++) s.push_back($urandom());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, " mem_wen"},   mem_wen,   32'd0);
        chk({nm, " mem_addr"},  mem_addr,  32'd0);
        chk({nm, " mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, " in_ready"},  in_ready,  32'd0);
        chk({nm, " cpu_rst"},   cpu_rst,   32'd1);
        chk({nm, " eof_addr"},  eof_addr,  32'd0);
        chk({nm, " done"},      done,      32'd0);
        chk({nm, " error"},     error,     32'd0);
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid
    task automatic run_stream(input string nm, input logic [31:0] s[$], input int mode);
        wr_t         w[$];
        bit          pay[$];
        int          used, ptr = 0, cyc = 0, lat_n = 0, lat_bad = 0, mm = -1;
        bit          md, me, acc, pend = 0, tmo = 0;
        logic [31:0] meof, pend_w = '0;
        model(s, w, pay, used, md, me, meof);
        got_q.delete();
        collect = 1;
        while (ptr < used) begin
            @(negedge clk);
            if (pend) begin
                lat_n++;
                if (!(mem_wen === 1'b1 && mem_wdata === pend_w)) lat_bad++;
            end
            pend = 0;
            cyc++;
            if (cyc > 3000) begin tmo = 1; break; end
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = cyc[0];
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? s[ptr] : $urandom();
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
                if (pay[ptr]) begin pend = 1; pend_w = s[ptr]; end
                ptr++;
            end
        end
        @(negedge clk);
        if (pend) begin
            lat_n++;
            if (!(mem_wen === 1'b1 && mem_wdata === pend_w)) lat_bad++;
        end
        in_valid = 1'b0;
        repeat (140) @(negedge clk);
        collect = 0;
        chk({nm, " timeout"}, 32'(tmo), 32'd0);
        if (lat_n > 0) chk({nm, " late/missing writes"}, lat_bad, 32'd0);
        chk({nm, " write count"}, got_q.size(), w.size());
        for (int i = 0; i < got_q.size() && i < w.size(); i++)
            if (mm < 0 && got_q[i] !== w[i]) mm = i;
        total++;
        if (mm >= 0) begin
            bad++;
            $display("FAIL %s write[%0d]: got %h/%h want %h/%h", nm, mm,
                     got_q[mm].a, got_q[mm].d, w[mm].a, w[mm].d);
        end
        chk({nm, " done"},     done,     32'(md));
        chk({nm, " error"},    error,    32'(me));
        chk({nm, " cpu_rst"},  cpu_rst,  32'(!md));
        chk({nm, " eof_addr"}, eof_addr, meof);
        chk({nm, " in_ready"}, in_ready, 32'(!(md || me)));
    endtask

    vec_t        vt[13];
    logic [31:0] hs[$];
    logic [31:0] s[$];

    initial begin
        vt[0]  = mk(3, 32'h0000_0003, 32'h4000_0002, 32'hC000_0000, 0, 1, 0, 32'h1000C, 132);
        vt[1]  = mk(1, 32'h4000_0002, 0, 0, 0,                        0, 1, 32'h0,     0);
        vt[2]  = mk(1, 32'h0000_0065, 0, 0, 0,                        0, 1, 32'h0,     0);
        vt[3]  = mk(2, 32'h0000_0003, 32'h8000_0000, 0, 0,            0, 1, 32'h1000C, 32);
        vt[4]  = mk(2, 32'h0000_0028, 32'hC000_0000, 0, 0,            1, 0, 32'h100A0, 40);
        vt[5]  = mk(3, 32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 0, 1, 0, 32'h10000, 132);
        vt[6]  = mk(3, 32'h0000_0020, 32'h4000_0064, 32'hC000_0000, 0, 1, 0, 32'h10080, 132);
        vt[7]  = mk(1, 32'hC000_0000, 0, 0, 0,                        0, 1, 32'h0,     0);
        vt[8]  = mk(2, 32'h0000_0005, 32'h0000_0002, 0, 0,            0, 1, 32'h10014, 32);
        vt[9]  = mk(3, 32'h0000_0003, 32'h4000_0002, 32'h4000_0001, 0, 0, 1, 32'h1000C, 132);
        vt[10] = mk(2, 32'h0000_0003, 32'h4000_0065, 0, 0,            0, 1, 32'h1000C, 32);
        vt[11] = mk(2, 32'h0000_0064, 32'hC000_0000, 0, 0,            1, 0, 32'h10190, 100);
        vt[12] = mk(2, 32'h0ABC_0003, 32'hFFFF_0000, 0, 0,            1, 0, 32'h1000C, 32);

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_reset();
            hs.delete();
            for (int k = 0; k < vt[i].nh; k++) hs.push_back(vt[i].h[k]);
            build(hs, s);
            run_stream(nm, s, (i + 1) % 3);
            chk({nm, " tbl done"},  done,          32'(vt[i].e_done));
            chk({nm, " tbl error"}, error,         32'(vt[i].e_err));
            chk({nm, " tbl eof"},   eof_addr,      vt[i].e_eof);
            chk({nm, " tbl nwr"},   got_q.size(),  32'(vt[i].e_nwr));
        end

        // Reset in the middle of the data zero-fill, then reload from scratch.
        begin
            int ptr = 0, cyc = 0;
            bit acc;
            do_reset();
            hs.delete();
            hs.push_back(32'h0000_0003); hs.push_back(32'h4000_0002); hs.push_back(32'hC000_0000);
            build(hs, s);
            while (ptr < 7 && cyc < 100) begin
                @(negedge clk);
                in_valid = 1'b1; in_data = s[ptr];
                acc = in_ready;
                @(posedge clk);
                if (acc) ptr++;
                cyc++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            repeat (10) @(negedge clk);
            chk("midrst fill active", mem_wen, 32'd1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_reset_vals("midrst");
            rst = 1'b0;
            build(hs, s);
            run_stream("reload", s, 2);
            chk("reload tbl eof", eof_addr,     32'h1000C);
            chk("reload tbl nwr", got_q.size(), 32'd132);
        end

        for (int r = 0; r < 8; r++) begin
            int nh, sel, len;
            do_reset();
            hs.delete();
            nh = $urandom_range(1, 4);
            for (int k = 0; k < nh; k++) begin
                sel = $urandom_range(0, 9);
                len = ($urandom_range(0, 9) == 0) ? 101 : $urandom_range(0, 45);
                if (sel < 4)      hs.push_back({2'b00, 14'($urandom()), 16'(len)});
                else if (sel < 7) hs.push_back({2'b01, 14'($urandom()), 16'(len % 12 == 5 ? 101 : len % 12)});
                else if (sel < 9) hs.push_back({2'b11, 30'($urandom())});
                else              hs.push_back({2'b10, 30'($urandom())});
            end
            if (r < 4) begin
                hs.delete();
                hs.push_back({2'b00, 14'h0, 16'($urandom_range(0, 40))});
                hs.push_back({2'b01, 14'h0, 16'($urandom_range(0, 10))});
                hs.push_back({2'b11, 30'h0});
            end
            build(hs, s);
            run_stream($sformatf("rand%0d", r), s, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
